lcd_spi_phy: RTL and testbench
==============================

// Module: lcd_spi_phy
// PURPOSE
//  SPI master PHY (mode 0, MSB first) for the LCD panel, directly downstream of the LCD interface sequencer.
//  Shifts one left-justified word of 8/16/24/32 bits onto the panel pins per begin request.
//  Captures MISO into a right-justified rx word; returns busy/done handshake to the sequencer.
//  Holds chip select asserted across words under upstream cs_req control.
// PARAMETERS
//  CLK_DIV  2  SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV)
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   synchronous reset, active-high
//  tx_word   in   32  transmit data, left-justified (bit 31 sent first)
//  tx_len    in   2   word length: 0=8b 1=16b 2=24b 3=32b
//  begin     in   1   start request, sampled only when busy=0
//  busy      out  1   transfer in progress
//  done      out  1   1-cycle pulse, transfer complete, rx_word valid
//  rx_word   out  32  received bits, right-justified, upper bits zero
//  cs_req    in   1   upstream request to hold chip select asserted
//  lcd_sck   out  1   SPI clock, idles low
//  lcd_mosi  out  1   SPI data out
//  lcd_miso  in   1   SPI data in
//  lcd_cs_n  out  1   chip select, active-low
// BEHAVIOUR
//  Reset (sync, rst=1): busy=0 done=0 rx_word=0 lcd_sck=0 lcd_mosi=0 lcd_cs_n=1; FSM->IDLE, counters 0.
//  FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | FINISH) -> IDLE.
//  IDLE: begin=1 at edge k -> latch tx_word, tx_len into shift reg / N=8*(tx_len+1);
//   from edge k: busy=1, state SHIFT_LO, lcd_mosi=tx_word[31], lcd_sck=0.
//  SHIFT_LO: sck low CLK_DIV cycles; then sck=1, sample lcd_miso into rx shift LSB, -> SHIFT_HI.
//  SHIFT_HI: sck high CLK_DIV cycles; then sck=0; if bits remain shift tx left, mosi=next bit,
//   -> SHIFT_LO; else -> FINISH.
//  FINISH (one cycle view): busy=0, done=1, rx_word=captured N bits zero-extended; -> IDLE.
//  Latency: busy high exactly 2*CLK_DIV*N cycles; done in first cycle busy=0.
//  begin while busy=1: ignored, no queueing. begin in the done cycle: accepted (back-to-back).
//  lcd_cs_n registered = ~(cs_req | busy_next); CS asserts no later than the cycle mosi shows
//   bit 31, stays low for whole transfer even if cs_req drops mid-word, rises 1 cycle
//   after cs_req=0 once idle.
//  lcd_mosi holds last bit sent after transfer; changes only on sck falling phase or start.
//  tx_word/tx_len changes during busy have no effect (latched copy used).
//  rx_word holds value until next done; not cleared at begin.
//  Reset mid-transfer: abort immediately, outputs to reset values, no done pulse.
//  Bit counter 6b (0..32); divide counter $clog2(CLK_DIV+1) bits; no wrap beyond N.
// TESTING
//  1 CLK_DIV=2, tx_len=0, tx_word=32'hA5xx_xxxx, miso loopback -> 8 sck pulses, mosi 1010_0101,
//    busy 32 cycles, done once, rx_word=32'h0000_00A5.
//  2 tx_len=3, tx_word=32'hDEAD_BEEF, miso tied 1 -> 32 pulses, busy 128 cycles,
//    rx_word=32'hFFFF_FFFF.
//  3 cs_req=1, two back-to-back 16b words (begin in done cycle) -> lcd_cs_n low throughout,
//    no idle sck gap beyond done cycle; cs_req=0 after -> lcd_cs_n=1 one cycle later.
//  4 begin pulsed mid-transfer, tx_word changed mid-transfer -> ignored, output stream
//    unchanged, single done.
//  5 rst=1 after 10 bits of 32b word -> next edge sck=0 cs_n=1 busy=0, no done; fresh 8b
//    transfer afterwards correct.
//  6 CLK_DIV=1, 24b word 32'h1234_56xx -> sck=clk/2, busy 48 cycles, rx loopback 32'h0012_3456.

Source files
------------

// File: rtl/lcd_spi_phy.sv
// SPI mode-0 master PHY for the LCD panel: shifts one 8/16/24/32-bit word MSB first
// and captures MISO into a right-justified receive word.
module lcd_spi_phy #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tx_word,
   input  logic [1:0]  tx_len,
   // "begin" is a reserved word, so the start request port is begin_req
   input  logic        begin_req,
   output logic        busy,
   output logic        done,
   output logic [31:0] rx_word,
   input  logic        cs_req,
   output logic        lcd_sck,
   output logic        lcd_mosi,
   input  logic        lcd_miso,
   output logic        lcd_cs_n
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT_LO = 2'd1;
   localparam logic [1:0] SHIFT_HI = 2'd2;
   localparam logic [1:0] FINISH   = 2'd3;

   logic [1:0]    state;
   logic [DW-1:0] div_cnt;
   logic [5:0]    bit_cnt;
   logic [5:0]    bit_len;
   logic [5:0]    bit_nxt;
   logic [30:0]   tx_sh;
   logic [31:0]   rx_sh;
   logic          div_end;
   logic          start;
   logic          last;
   logic          busy_next;

   always_comb begin
      div_end   = (div_cnt == DIV_LAST);
      bit_nxt   = bit_cnt + 6'd1;
      start     = ((state == IDLE) || (state == FINISH)) && begin_req;
      last      = (state == SHIFT_HI) && div_end && (bit_nxt == bit_len);
      busy_next = start || (busy && !last);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         bit_len  <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_word  <= '0;
         lcd_sck  <= 1'b0;
         lcd_mosi <= 1'b0;
         lcd_cs_n <= 1'b1;
      end else begin
         done     <= 1'b0;
         busy     <= busy_next;
         lcd_cs_n <= ~(cs_req | busy_next);
         case (state)
            // FINISH doubles as an idle cycle so a begin in the done cycle starts at once
            IDLE, FINISH: begin
               if (begin_req) begin
                  state    <= SHIFT_LO;
                  tx_sh    <= tx_word[30:0];
                  bit_len  <= {({1'b0, tx_len} + 3'd1), 3'b000};
                  lcd_mosi <= tx_word[31];
                  lcd_sck  <= 1'b0;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  rx_sh    <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT_LO: begin
               if (div_end) begin
                  lcd_sck <= 1'b1;
                  rx_sh   <= {rx_sh[30:0], lcd_miso};
                  div_cnt <= '0;
                  state   <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  lcd_sck <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= bit_nxt;
                  if (bit_nxt == bit_len) begin
                     state   <= FINISH;
                     done    <= 1'b1;
                     rx_word <= rx_sh;
                  end else begin
                     tx_sh    <= {tx_sh[29:0], 1'b0};
                     lcd_mosi <= tx_sh[30];
                     state    <= SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_spi_phy.sv
// Bench for lcd_spi_phy: two instances (CLK_DIV=2 and CLK_DIV=1) checked against a
// bit-sequence model of the SPI transfer.
module tb_lcd_spi_phy;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tx_word;
   logic [1:0]  tx_len;
   logic        begin_req;
   logic        cs_req;

   logic        busy_a, done_a, sck_a, mosi_a, miso_a, cs_n_a;
   logic [31:0] rx_a;
   logic        busy_b, done_b, sck_b, mosi_b, miso_b, cs_n_b;
   logic [31:0] rx_b;

   logic        o_busy, o_done, o_sck, o_mosi, o_cs_n;
   logic [31:0] o_rx;

   int          checks = 0;
   int          errors = 0;
   bit          sel = 1'b0;
   int          miso_mode = 0;
   logic [5:0]  rise_cnt = '0;
   logic [31:0] pat = '0;

   always #5 clk = ~clk;

   lcd_spi_phy #(.CLK_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .tx_word(tx_word), .tx_len(tx_len), .begin_req(begin_req),
      .busy(busy_a), .done(done_a), .rx_word(rx_a), .cs_req(cs_req),
      .lcd_sck(sck_a), .lcd_mosi(mosi_a), .lcd_miso(miso_a), .lcd_cs_n(cs_n_a));

   lcd_spi_phy #(.CLK_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .tx_word(tx_word), .tx_len(tx_len), .begin_req(begin_req),
      .busy(busy_b), .done(done_b), .rx_word(rx_b), .cs_req(cs_req),
      .lcd_sck(sck_b), .lcd_mosi(mosi_b), .lcd_miso(miso_b), .lcd_cs_n(cs_n_b));

   // miso source: 0 loopback, 1 tied high, 2 random pattern indexed by bit number
   always_comb begin
      miso_a = (miso_mode == 0) ? mosi_a : (miso_mode == 1) ? 1'b1 : pat[rise_cnt[4:0]];
      miso_b = (miso_mode == 0) ? mosi_b : (miso_mode == 1) ? 1'b1 : pat[rise_cnt[4:0]];
   end

   always_comb begin
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      o_sck  = sel ? sck_b  : sck_a;
      o_mosi = sel ? mosi_b : mosi_a;
      o_cs_n = sel ? cs_n_b : cs_n_a;
      o_rx   = sel ? rx_b   : rx_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Received word = the N sampled MISO bits, first bit most significant
   function automatic logic [31:0] model_rx(input logic [31:0] w, input int n,
                                            input int mode, input logic [31:0] p);
      logic [31:0] r;
      logic        b;
      r = '0;
      for (int j = 0; j < n; j++) begin
         b = (mode == 0) ? w[31-j] : (mode == 1) ? 1'b1 : p[j];
         r = {r[30:0], b};
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge where done is observed.
   task automatic do_xfer(input logic [31:0] w, input logic [1:0] len, input int mode,
                          input bit hold, input bit disturb);
      int          n, d, busy_cnt, rises, cs_bad, budget;
      logic        prev_sck;
      logic [31:0] mosi_bits;
      bit          seen_done, start_ok;
      n = 8 * (int'(len) + 1);
      d = sel ? 1 : 2;
      busy_cnt = 0; rises = 0; cs_bad = 0;
      prev_sck = 1'b0; mosi_bits = '0; seen_done = 1'b0; start_ok = 1'b0;
      budget = 2 * d * n + 8;
      pat = $urandom;
      miso_mode = mode;
      rise_cnt = '0;
      cs_req = hold;
      tx_word = w;
      tx_len = len;
      begin_req = 1'b1;
      for (int c = 0; c < budget && !seen_done; c++) begin
         @(negedge clk);
         if (c == 0) begin
            begin_req = 1'b0;
            start_ok = o_busy;
         end
         if (disturb && c == n) begin
            begin_req = 1'b1;
            tx_word = ~w;
            tx_len = ~len;
         end else if (disturb && c == n + 1) begin
            begin_req = 1'b0;
         end
         if (o_busy) busy_cnt++;
         if (o_sck && !prev_sck) begin
            mosi_bits = {mosi_bits[30:0], o_mosi};
            rises++;
            rise_cnt = rise_cnt + 6'd1;
         end
         prev_sck = o_sck;
         if (o_cs_n !== !(o_busy || hold)) cs_bad++;
         if (o_done) seen_done = 1'b1;
      end
      chk("busy_at_start", 32'(start_ok), 32'd1);
      chk("done_seen", 32'(seen_done), 32'd1);
      chk("busy_low_at_done", 32'(o_busy), 32'd0);
      chk("busy_cycles", 32'(busy_cnt), 32'(2 * d * n));
      chk("sck_pulses", 32'(rises), 32'(n));
      chk("mosi_stream", mosi_bits, w >> (32 - n));
      chk("rx_word", o_rx, model_rx(w, n, mode, pat));
      chk("cs_n_track", 32'(cs_bad), 32'd0);
      chk("sck_idle_at_done", 32'(o_sck), 32'd0);
      chk("mosi_holds_last", 32'(o_mosi), 32'(w[32 - n]));
   endtask

   task automatic idle_chk();
      @(negedge clk);
      chk("done_pulse_width", 32'(o_done), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
   endtask

   initial begin
      logic [31:0] rx_before;
      int          rises5;
      logic        prev5;
      bit          done5;

      rst = 1'b1; tx_word = '0; tx_len = '0; begin_req = 1'b0; cs_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
      chk("rst_done", 32'({done_a, done_b}), 32'd0);
      chk("rst_rx_a", rx_a, 32'd0);
      chk("rst_rx_b", rx_b, 32'd0);
      chk("rst_sck_mosi", 32'({sck_a, mosi_a, sck_b, mosi_b}), 32'd0);
      chk("rst_cs_n", 32'({cs_n_a, cs_n_b}), 32'd3);
      rst = 1'b0;
      @(negedge clk);

      // 8-bit loopback, CLK_DIV=2
      sel = 1'b0;
      do_xfer({8'hA5, 24'($urandom)}, 2'd0, 0, 1'b0, 1'b0);
      chk("t1_rx_const", o_rx, 32'h0000_00A5);
      idle_chk();

      // 32-bit, miso tied high
      do_xfer(32'hDEAD_BEEF, 2'd3, 1, 1'b0, 1'b0);
      chk("t2_rx_const", o_rx, 32'hFFFF_FFFF);
      idle_chk();

      // back-to-back 16-bit words with chip select held
      do_xfer($urandom, 2'd1, 2, 1'b1, 1'b0);
      do_xfer($urandom, 2'd1, 0, 1'b1, 1'b0);
      cs_req = 1'b0;
      @(negedge clk);
      chk("cs_release", 32'(o_cs_n), 32'd1);
      chk("b2b_single_done", 32'(o_done), 32'd0);

      // begin and tx_word disturbed mid-transfer
      do_xfer($urandom, 2'd3, 0, 1'b0, 1'b1);
      idle_chk();

      for (int i = 0; i < 4; i++) begin
         do_xfer($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'b0);
         idle_chk();
      end
      cs_req = 1'b0;
      @(negedge clk);

      // reset after 10 bits of a 32-bit word
      rx_before = o_rx;
      miso_mode = 0; tx_word = $urandom; tx_len = 2'd3; begin_req = 1'b1;
      rises5 = 0; prev5 = 1'b0; done5 = 1'b0;
      for (int c = 0; c < 400 && rises5 < 10; c++) begin
         @(negedge clk);
         if (c == 0) begin_req = 1'b0;
         if (o_sck && !prev5) rises5++;
         prev5 = o_sck;
      end
      chk("t5_bits_before_reset", 32'(rises5), 32'd10);
      chk("t5_busy_before_reset", 32'(o_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_sck", 32'(o_sck), 32'd0);
      chk("t5_cs_n", 32'(o_cs_n), 32'd1);
      chk("t5_busy", 32'(o_busy), 32'd0);
      chk("t5_mosi", 32'(o_mosi), 32'd0);
      chk("t5_rx_cleared", o_rx, (rx_before == 32'd0) ? 32'd0 : 32'd0);
      if (o_done) done5 = 1'b1;
      @(negedge clk);
      if (o_done) done5 = 1'b1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (o_done) done5 = 1'b1;
      end
      chk("t5_no_done", 32'(done5), 32'd0);
      chk("t5_idle_busy", 32'(o_busy), 32'd0);
      do_xfer($urandom, 2'd0, 2, 1'b0, 1'b0);
      idle_chk();

      // CLK_DIV=1 instance
      sel = 1'b1;
      do_xfer({24'h123456, 8'($urandom)}, 2'd2, 0, 1'b0, 1'b0);
      chk("t6_rx_const", o_rx, 32'h0012_3456);
      idle_chk();
      for (int i = 0; i < 4; i++) begin
         do_xfer($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'b0);
         idle_chk();
      end
      cs_req = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
